// File: rtl/ker_sram_writer_if.sv
// Bundle for ker_sram_writer: start/config, FIFO pop side, status and the
// kernel-SRAM write strobes. master drives the stream, slave is the writer.
interface ker_sram_writer_if #(
    parameter int DATA_W   = 64,
    parameter int NUM_BANK = 8,
    parameter int ADDR_W   = 11,
    parameter int CNT_W    = 16
);
    logic                start_ker_store;
    logic [CNT_W-1:0]    cfg_ker_num;
    logic [ADDR_W-1:0]   cfg_ker_words;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [DATA_W-1:0]   ker_store_data_din;
    logic                ker_store_empty_n_din;
    logic                ker_store_read_dout;
    logic                ker_store_busy;
    logic                ker_store_done;
    logic [NUM_BANK-1:0] cen_kersr;
    logic [NUM_BANK-1:0] wen_kersr;
    logic [ADDR_W-1:0]   addr_kersr;
    logic [DATA_W-1:0]   din_kersr;

    modport master (
        output start_ker_store, cfg_ker_num, cfg_ker_words, cfg_base_addr,
        output ker_store_data_din, ker_store_empty_n_din,
        input  ker_store_read_dout, ker_store_busy, ker_store_done,
        input  cen_kersr, wen_kersr, addr_kersr, din_kersr
    );

    modport slave (
        input  start_ker_store, cfg_ker_num, cfg_ker_words, cfg_base_addr,
        input  ker_store_data_din, ker_store_empty_n_din,
        output ker_store_read_dout, ker_store_busy, ker_store_done,
        output cen_kersr, wen_kersr, addr_kersr, din_kersr
    );
endinterface

// File: rtl/ker_sram_writer.sv
// Kernel-SRAM store engine: FWFT stream -> NUM_BANK banks, kernel k at bank k%NB.
// Optional XOR checksum of popped words under `define KER_WR_CHKSUM_EN.
module ker_sram_writer #(
    parameter int DATA_W   = 64,
    parameter int NUM_BANK = 8,
    parameter int ADDR_W   = 11,
    parameter int CNT_W    = 16
) (
    input logic clk,
    input logic reset,
    ker_sram_writer_if.slave bus
`ifdef KER_WR_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] ker_chksum
`endif
);
    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    state_t              state;
    logic                busy;
    logic                done;
    logic [NUM_BANK-1:0] cen;
    logic [NUM_BANK-1:0] wen;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   din;
    logic [CNT_W-1:0]    ker_num;
    logic [ADDR_W-1:0]   words;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   w;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   slot_base;
    logic [CNT_W-1:0]    k;
    logic                pop;
    logic                w_last;
    logic                bank_last;
    logic                run_last;
    logic [NUM_BANK-1:0] sel;
`ifdef KER_WR_CHKSUM_EN
    logic [DATA_W-1:0]   chksum;
    assign ker_chksum = chksum;
`endif

    assign pop       = (state == LOAD) && bus.ker_store_empty_n_din;
    assign w_last    = (w == words - ADDR_W'(1));
    assign bank_last = (bank == BANK_W'(NUM_BANK - 1));
    assign run_last  = w_last && (k == ker_num - CNT_W'(1));
    assign sel       = NUM_BANK'(1) << bank;

    assign bus.ker_store_read_dout = pop;
    assign bus.ker_store_busy      = busy;
    assign bus.ker_store_done      = done;
    assign bus.cen_kersr           = cen;
    assign bus.wen_kersr           = wen;
    assign bus.addr_kersr          = addr;
    assign bus.din_kersr           = din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cen       <= '1;
            wen       <= '1;
            addr      <= '0;
            din       <= '0;
            ker_num   <= '0;
            words     <= '0;
            base      <= '0;
            w         <= '0;
            bank      <= '0;
            slot_base <= '0;
            k         <= '0;
`ifdef KER_WR_CHKSUM_EN
            chksum    <= '0;
`endif
        end else begin
            cen  <= '1;
            wen  <= '1;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_ker_store) begin
                        ker_num   <= bus.cfg_ker_num;
                        words     <= bus.cfg_ker_words;
                        base      <= bus.cfg_base_addr;
                        w         <= '0;
                        bank      <= '0;
                        slot_base <= '0;
                        k         <= '0;
                        busy      <= 1'b1;
`ifdef KER_WR_CHKSUM_EN
                        chksum    <= '0;
`endif
                        // Empty job skips LOAD but still reports completion
                        if (bus.cfg_ker_num != '0 && bus.cfg_ker_words != '0) begin
                            state <= LOAD;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pop) begin
                        cen  <= ~sel;
                        wen  <= ~sel;
                        addr <= base + slot_base + w;
                        din  <= bus.ker_store_data_din;
`ifdef KER_WR_CHKSUM_EN
                        chksum <= chksum ^ bus.ker_store_data_din;
`endif
                        if (w_last) begin
                            w <= '0;
                            k <= k + CNT_W'(1);
                            if (bank_last) begin
                                bank      <= '0;
                                slot_base <= slot_base + words;
                            end else begin
                                bank <= bank + BANK_W'(1);
                            end
                        end else begin
                            w <= w + ADDR_W'(1);
                        end
                        if (run_last) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ker_sram_writer.sv
// Directed bench for ker_sram_writer: FIFO model feeds a write scoreboard
// built from the kernel->bank/slot mapping; monitor pops it on every strobe.
module tb_ker_sram_writer;
    localparam int DW = 64;
    localparam int NB = 8;
    localparam int AW = 11;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ker_sram_writer_if #(.DATA_W(DW), .NUM_BANK(NB), .ADDR_W(AW), .CNT_W(CW)) bus ();

`ifdef KER_WR_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    ker_sram_writer #(.DATA_W(DW), .NUM_BANK(NB), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef KER_WR_CHKSUM_EN
        ,
        .ker_chksum(chksum)
`endif
    );

    typedef struct packed {
        logic [NB-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int passed = 0;
    int total = 0;
    int m_words = 1;
    int m_base = 0;
    int pops = 0;
    int writes = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    int done_wr = 0;
    logic [DW-1:0] m_xor = '0;
    logic [DW-1:0] fifo_word = '0;
    bit fifo_on = 1'b0;
    bit gap_mode = 1'b0;
    bit tog = 1'b0;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // FIFO model: record the expected write for every accepted pop
    always @(posedge clk) begin
        int kk, ww;
        wr_t e;
        if (bus.ker_store_read_dout === 1'b1) begin
            kk = pops / m_words;
            ww = pops % m_words;
            e.sel  = NB'(1) << (kk % NB);
            e.addr = AW'(m_base + (kk / NB) * m_words + ww);
            e.data = fifo_word;
            sb.push_back(e);
            m_xor = m_xor ^ fifo_word;
            pops++;
            fifo_word = fifo_word + 64'd1;
        end
        #1;
        tog = ~tog;
        bus.ker_store_empty_n_din = fifo_on && (!gap_mode || tog);
        bus.ker_store_data_din = fifo_word;
    end

    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (bus.ker_store_busy === 1'b1) busy_cyc++;
            chk("read_gate", 256'(bus.ker_store_read_dout & ~bus.ker_store_empty_n_din), 256'(0));
            if (bus.cen_kersr !== '1) begin
                writes++;
                if (sb.size() == 0) begin
                    chk("write_no_expect", 256'(bus.cen_kersr), 256'({NB{1'b1}}));
                end else begin
                    e = sb.pop_front();
                    chk("sram_write",
                        256'({bus.cen_kersr, bus.wen_kersr, bus.addr_kersr, bus.din_kersr}),
                        256'({~e.sel, ~e.sel, e.addr, e.data}));
                end
            end
            if (bus.ker_store_done === 1'b1) begin
                done_cnt++;
                if (bus.cen_kersr !== '1) done_wr++;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(int n, int w, int b);
        m_words = (w == 0) ? 1 : w;
        m_base = b;
        pops = 0;
        writes = 0;
        busy_cyc = 0;
        done_cnt = 0;
        done_wr = 0;
        m_xor = '0;
        bus.cfg_ker_num = CW'(n);
        bus.cfg_ker_words = AW'(w);
        bus.cfg_base_addr = AW'(b);
        bus.start_ker_store = 1'b1;
        cyc(1);
        bus.start_ker_store = 1'b0;
    endtask

    task automatic wait_done(string tag, int limit);
        int i = 0;
        while (done_cnt == 0 && i < limit) begin
            cyc(1);
            i++;
        end
        chk({tag, "_done_in_time"}, 256'(done_cnt != 0), 256'(1));
        cyc(3);
    endtask

    task automatic end_checks(string tag, int n, int w, int busy_exp);
        chk({tag, "_pops"}, 256'(pops), 256'(n * w));
        chk({tag, "_writes"}, 256'(writes), 256'(n * w));
        chk({tag, "_sb_left"}, 256'(sb.size()), 256'(0));
        chk({tag, "_done_cnt"}, 256'(done_cnt), 256'(1));
        if (busy_exp >= 0) chk({tag, "_busy_cyc"}, 256'(busy_cyc), 256'(busy_exp));
        if (n * w > 0) chk({tag, "_done_with_last_wr"}, 256'(done_wr), 256'(1));
`ifdef KER_WR_CHKSUM_EN
        chk({tag, "_chksum"}, 256'(chksum), 256'(m_xor));
`endif
    endtask

    initial begin
        int i;
        bus.start_ker_store = 1'b0;
        bus.cfg_ker_num = '0;
        bus.cfg_ker_words = '0;
        bus.cfg_base_addr = '0;
        bus.ker_store_empty_n_din = 1'b0;
        bus.ker_store_data_din = '0;
        cyc(2);
        chk("reset_state",
            256'({bus.ker_store_read_dout, bus.ker_store_busy, bus.ker_store_done,
                  bus.cen_kersr, bus.wen_kersr, bus.addr_kersr, bus.din_kersr}),
            256'({3'b000, {NB{1'b1}}, {NB{1'b1}}, {AW{1'b0}}, {DW{1'b0}}}));
`ifdef KER_WR_CHKSUM_EN
        chk("reset_chksum", 256'(chksum), 256'(0));
`endif
        reset = 1'b0;
        cyc(2);
        fifo_on = 1'b1;

        // T1: 8 kernels x 4 words, full FIFO
        fifo_word = '0;
        start_run(8, 4, 0);
        wait_done("t1", 100);
        end_checks("t1", 8, 4, 33);

        // T2: 10 kernels x 3 words at base 5, with a stray start mid-run
        start_run(10, 3, 5);
        cyc(4);
        bus.cfg_ker_num = CW'(1);
        bus.cfg_ker_words = AW'(1);
        bus.cfg_base_addr = AW'(100);
        bus.start_ker_store = 1'b1;
        cyc(1);
        bus.start_ker_store = 1'b0;
        wait_done("t2", 100);
        end_checks("t2", 10, 3, 31);

        // T3: FIFO ready every other cycle
        gap_mode = 1'b1;
        fifo_word = '0;
        start_run(8, 4, 0);
        wait_done("t3", 200);
        end_checks("t3", 8, 4, -1);
        gap_mode = 1'b0;

        // T4: empty jobs
        start_run(0, 4, 0);
        wait_done("t4_n0", 3);
        end_checks("t4_n0", 0, 4, 1);
        start_run(5, 0, 0);
        wait_done("t4_w0", 3);
        end_checks("t4_w0", 5, 0, 1);

        // T5: reset after 10 pops, then a clean restart
        fifo_word = '0;
        start_run(8, 4, 0);
        i = 0;
        while (pops < 10 && i < 50) begin
            cyc(1);
            i++;
        end
        chk("t5_pops_before_reset", 256'(pops), 256'(10));
        reset = 1'b1;
        @(negedge clk);
        chk("t5_after_reset",
            256'({bus.cen_kersr, bus.wen_kersr, bus.ker_store_busy,
                  bus.ker_store_done, bus.ker_store_read_dout}),
            256'({{NB{1'b1}}, {NB{1'b1}}, 3'b000}));
        sb.delete();
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("t5_no_done", 256'(done_cnt), 256'(0));
        fifo_word = '0;
        start_run(8, 4, 0);
        wait_done("t5_restart", 100);
        end_checks("t5_restart", 8, 4, 33);

        // T6: address wrap on bank 0
        fifo_word = '0;
        start_run(1, 16, 2040);
        wait_done("t6", 100);
        end_checks("t6", 1, 16, 17);
`ifdef KER_WR_CHKSUM_EN
        chk("t6_xor_zero", 256'(chksum), 256'(0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
